// File: rtl/tt_um_emern_spi_pkg.sv
// tt_um_emern_spi_pkg: shared state encoding, parameter defaults and length clamp for the SPI host
package tt_um_emern_spi_pkg;
   typedef enum logic [2:0] {S_IDLE, S_WAIT_INT, S_SETUP, S_SHIFT, S_HOLD} state_e;
   localparam int CLK_DIV_DEF   = 4;
   localparam int MAX_BYTES_DEF = 4;
   function automatic logic [2:0] clamp_len(input logic [2:0] len, input int max_b);
      return (int'(len) > max_b) ? 3'(max_b) : len;
   endfunction
endpackage

// File: rtl/tt_um_emern_sck_tick.sv
// tt_um_emern_sck_tick: half-period down-counter, tick on zero, reloaded on clear or tick
module tt_um_emern_sck_tick #(
   parameter int DIV = 4
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr_i,
   output logic tick_o
);
   logic [7:0] cnt_q;
   assign tick_o = cnt_q == 8'd0;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n)                cnt_q <= 8'd0;
      else if (clr_i || tick_o)  cnt_q <= 8'(DIV - 1);
      else                       cnt_q <= cnt_q - 8'd1;
endmodule

// File: rtl/tt_um_emern_spi_host.sv
// tt_um_emern_spi_host: SPI mode-0 host sending up to MAX_BYTES per frame, MSB first.
// Define EMERN_SPI_HOST_INT_GATE_EN to hold each frame in WAIT_INT until int_in is seen high.
module tt_um_emern_spi_host
   import tt_um_emern_spi_pkg::*;
#(
   parameter int CLK_DIV   = CLK_DIV_DEF,
   parameter int MAX_BYTES = MAX_BYTES_DEF
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic [2:0]  cmd_len,
   input  logic [31:0] cmd_data,
   input  logic        int_in,
   output logic        cs_out,
   output logic        sck_out,
   output logic        mosi_out,
   input  logic        miso_in,
   output logic        rx_valid,
   output logic [7:0]  rx_data,
   output logic        busy
);
   state_e      state_q, state_d;
   logic [31:0] tx_q, tx_d;
   logic [2:0]  len_q, len_d;
   logic [6:0]  hcnt_q, hcnt_d, last_h;
   logic [2:0]  bcnt_q, bcnt_d;
   logic [6:0]  rx_sh_q, rx_sh_d;
   logic [7:0]  rx_data_q, rx_data_d, rx_next;
   logic        rx_valid_q, rx_valid_d;
   logic        sck_q, sck_d;
   logic        rdy_q;
   logic        tick, clr, sample;

`ifdef EMERN_SPI_HOST_INT_GATE_EN
   logic int_q;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) int_q <= 1'b0;
      else        int_q <= int_in;
`else
   logic unused_int;
   assign unused_int = int_in;
`endif

   tt_um_emern_sck_tick #(.DIV(CLK_DIV)) u_tick (
      .clk    (clk),
      .rst_n  (rst_n),
      .clr_i  (clr),
      .tick_o (tick)
   );

   assign cs_out    = (state_q == S_IDLE) || (state_q == S_WAIT_INT);
   assign busy      = state_q != S_IDLE;
   assign cmd_ready = rdy_q && (state_q == S_IDLE);
   assign sck_out   = sck_q;
   assign mosi_out  = !cs_out && tx_q[31];
   assign rx_valid  = rx_valid_q;
   assign rx_data   = rx_data_q;
   assign rx_next   = {rx_sh_q, miso_in};
   assign last_h    = {len_q, 4'b0000} - 7'd1;
   assign clr       = (state_d == S_SETUP) && (state_q != S_SETUP);

   always_comb begin
      state_d    = state_q;
      tx_d       = tx_q;
      len_d      = len_q;
      hcnt_d     = hcnt_q;
      bcnt_d     = bcnt_q;
      rx_sh_d    = rx_sh_q;
      rx_data_d  = rx_data_q;
      rx_valid_d = 1'b0;
      sck_d      = sck_q;
      sample     = 1'b0;
      case (state_q)
         S_IDLE: if (cmd_valid && cmd_ready) begin
            tx_d   = cmd_data;
            len_d  = clamp_len(cmd_len, MAX_BYTES);
            hcnt_d = 7'd0;
            bcnt_d = 3'd0;
`ifdef EMERN_SPI_HOST_INT_GATE_EN
            if (cmd_len != 3'd0) state_d = S_WAIT_INT;
`else
            if (cmd_len != 3'd0) state_d = S_SETUP;
`endif
         end
`ifdef EMERN_SPI_HOST_INT_GATE_EN
         S_WAIT_INT: if (int_q) state_d = S_SETUP;
`endif
         S_SETUP: if (tick) begin
            sck_d   = 1'b1;
            sample  = 1'b1;
            state_d = S_SHIFT;
         end
         // the final low half-period ends the frame instead of raising sck again
         S_SHIFT: if (tick) begin
            hcnt_d = hcnt_q + 7'd1;
            if (hcnt_q == last_h) state_d = S_HOLD;
            else begin
               sck_d = !sck_q;
               if (sck_q) tx_d = {tx_q[30:0], 1'b0};
               else       sample = 1'b1;
            end
         end
         S_HOLD: if (tick) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
      if (sample) begin
         rx_sh_d = rx_next[6:0];
         bcnt_d  = bcnt_q + 3'd1;
         if (bcnt_q == 3'd7) begin
            rx_valid_d = 1'b1;
            rx_data_d  = rx_next;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state_q    <= S_IDLE;
         tx_q       <= '0;
         len_q      <= '0;
         hcnt_q     <= '0;
         bcnt_q     <= '0;
         rx_sh_q    <= '0;
         rx_data_q  <= '0;
         rx_valid_q <= 1'b0;
         sck_q      <= 1'b0;
         rdy_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         tx_q       <= tx_d;
         len_q      <= len_d;
         hcnt_q     <= hcnt_d;
         bcnt_q     <= bcnt_d;
         rx_sh_q    <= rx_sh_d;
         rx_data_q  <= rx_data_d;
         rx_valid_q <= rx_valid_d;
         sck_q      <= sck_d;
         rdy_q      <= 1'b1;
      end
endmodule
